weight_buffer_stream: RTL and testbench
=======================================

# weight_buffer_stream

Parametrised, multi-bank weight store for the CLSTM datapath. It streams a run of consecutive weight rows to the matrix-vector units under a ready/valid handshake. Each bank holds `DEPTH` rows of `LANES` packed words. For every issued row index, all banks are read in parallel, and bank `b` reads physical row `index + b*DEPTH`. The block sits between the layer controller, which issues run commands, and the MAC array, which consumes `q_data`.

## Interface

Parameters:
- `BIT_WIDTH`, 18: width of one weight word.
- `LANES`, 9: words packed per bank row.
- `BANKS`, 2: parallel banks, i.e. output row groups.
- `DEPTH`, 42: logical rows per bank.
- `ADDR_WIDTH`, 12: index/address width; must satisfy `BANKS*DEPTH <= 2**ADDR_WIDTH`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `rd_start`  in  1: run request; accepted only when `busy`=0.
- `rd_base`  in  ADDR_WIDTH: first logical row of the run, `0..DEPTH-1`.
- `rd_count`  in  ADDR_WIDTH: rows in the run; 0 means no-op.
- `busy`  out  1: a run is in progress.
- `q_valid`  out  1: `q_data` holds a valid row set.
- `q_ready`  in  1: consumer accepts `q_data`.
- `q_last`  out  1: the current beat is the final row of the run.
- `q_data`  out  BANKS*LANES*BIT_WIDTH: bank `b`, lane `l` word at bits `[(b*LANES+l)*BIT_WIDTH +: BIT_WIDTH]`.
- `load_valid`, `load_ready`, `load_bank[$clog2(BANKS)]`, `load_addr[ADDR_WIDTH]`, `load_data[LANES*BIT_WIDTH]`: weight preload port; present only under the macro in Configuration.

## Operation

- FSM states: IDLE, RUN, DRAIN. `busy` = (state != IDLE).
- IDLE → RUN when `rd_start`=1 and `rd_count`≠0. On that edge, `rd_base` and `rd_count` are latched.
- `rd_start` with `rd_count`=0 is ignored. `rd_start` while `busy`=1 is ignored.
- Pipeline advance enable: `adv` = ~`q_valid` | `q_ready`.
- In RUN, one logical index is issued per cycle in which `adv`=1.
- Index sequence: `base`, `base+1`, … with modulo-`DEPTH` wrap (`DEPTH-1` → 0). An index never leaves its bank's region.
- Per bank: address register = `index + b*DEPTH`. The RAM output register updates only when `adv`=1.
- When `adv`=0, the issue counter, the address registers, the RAM outputs and `q_data` all hold their values.
- RUN → DRAIN on the edge that issues the final index.
- DRAIN → IDLE on the edge where the beat with `q_last`=1 is accepted (`q_valid` & `q_ready`).
- `q_last` travels down the pipeline with the final index.
- Load port: `load_ready` = ~`busy`. A write occurs on `load_valid` & `load_ready` to physical row `load_addr + load_bank*DEPTH`. The write completes in one cycle.
- A `rd_start` in the same cycle as a load: the load wins and `rd_start` is ignored. The controller retries.
- Out-of-range `rd_base` or `load_addr` (≥ `DEPTH`) is undefined. It is flagged only by the simulation assertion in the package.

## Timing

- Reset values: `busy`=0, `q_valid`=0, `q_last`=0, `q_data`=0, `load_ready`=1, state IDLE.
- The RAM array is not reset; its contents survive `resetn`.
- Reset mid-run aborts the run immediately. No further beats are produced after `resetn` rises.
- Latency: the start is accepted at edge 0, and the first `q_valid`=1 appears after edge 2 (address register, then RAM register).
- Throughput: 1 row per cycle while `q_ready`=1.
- A run of N rows completes in N+2 cycles with no stalls.
- While `q_valid`=1 and `q_ready`=0, `q_data` and `q_last` are stable.
- The earliest next accepted `rd_start` is the cycle after the return to IDLE.

## Configuration

- `WEIGHT_BUFFER_LOAD_EN` defined: the load port exists, and the RAM is writable at run time.
- `WEIGHT_BUFFER_LOAD_EN` undefined:
  - The load ports are omitted.
  - The RAM write enable is tied to 0, making the store a ROM initialised only by simulation/synthesis memory init.
  - `load_ready` does not exist.

## Structure

- Package `weight_buffer_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the packed-width function `row_bits(LANES, BIT_WIDTH)`;
  - the wrap-increment helper;
  - the `DEPTH`/`ADDR_WIDTH` legality assertion.
- Sub-module `weight_bank_ram` is a single-port synchronous RAM with registered output and a clock-enable input. It is instantiated `BANKS` times in a generate loop.

## Test plan

Defaults are used; the preload value is `word = {bank, row, lane}` packed into 18 bits.

- Start base 0, count 42, `q_ready`=1 → 42 beats on consecutive cycles. The first beat appears 2 cycles after accept. Beat k has bank1 lane l = {1, k, l}. `q_last` is high on beat 41 only. `busy` drops the cycle after beat 41.
- Base 40, count 4 → beats carry rows 40, 41, 0, 1 in both banks.
- `q_ready` toggled at random during count 10 → exactly 10 beats, in order, with `q_data` held during every stall.
- Count 0, or `rd_start` while busy → no beats and no state change.
- Assert `resetn` low at beat 3 of a 20-row run → outputs return to their reset values. Then a new run with base 5, count 2 returns rows 5 and 6 with the preloaded data intact.
- With `WEIGHT_BUFFER_LOAD_EN`, write bank 1 row 7 = all-ones, then read base 7, count 1 → bank1 lanes are all `0x3FFFF` and bank0 is unchanged. `load_ready` is 0 while busy.

Source files
------------

// File: rtl/weight_buffer_pkg.sv
// Shared types and helpers for the CLSTM weight buffer.
// WEIGHT_BUFFER_LOAD_EN enables the run-time preload port.
package weight_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wb_state_t;

    function automatic int row_bits(input int lanes, input int bit_width);
        return lanes * bit_width;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned depth);
        return (idx + 1 >= depth) ? 0 : idx + 1;
    endfunction

    function automatic bit cfg_legal(input int banks, input int depth,
                                     input int aw);
        return (longint'(banks) * depth) <= (longint'(1) << aw);
    endfunction

    function automatic bit in_range(input int unsigned addr,
                                    input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// One weight bank: single-port synchronous RAM, registered output.
// Physical addresses are offset by BASE; only this bank's rows are stored.
module weight_bank_ram #(
    parameter int WIDTH = 162,
    parameter int WORDS = 42,
    parameter int AW    = 12,
    parameter int BASE  = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ce,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] dout
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [WIDTH-1:0] mem [WORDS];
    logic [IW-1:0]    loc;

    assign loc = IW'(addr - AW'(BASE));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[loc] <= wdata;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout <= '0;
        end else if (ce) begin
            dout <= mem[loc];
        end
    end

endmodule

// File: rtl/weight_buffer_stream.sv
// Multi-bank weight store streaming row runs over ready/valid.
// WEIGHT_BUFFER_LOAD_EN adds the preload port; otherwise the store is a ROM.
module weight_buffer_stream
    import weight_buffer_pkg::*;
#(
    parameter int BIT_WIDTH  = 18,
    parameter int LANES      = 9,
    parameter int BANKS      = 2,
    parameter int DEPTH      = 42,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                rd_start,
    input  logic [ADDR_WIDTH-1:0]               rd_base,
    input  logic [ADDR_WIDTH-1:0]               rd_count,
    output logic                                busy,
    output logic                                q_valid,
    input  logic                                q_ready,
    output logic                                q_last,
    output logic [BANKS*LANES*BIT_WIDTH-1:0]    q_data
`ifdef WEIGHT_BUFFER_LOAD_EN
    ,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic [$clog2(BANKS)-1:0]            load_bank,
    input  logic [ADDR_WIDTH-1:0]               load_addr,
    input  logic [LANES*BIT_WIDTH-1:0]          load_data
`endif
);

    localparam int RW = row_bits(LANES, BIT_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    wb_state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] left;
    logic                  s1_valid;
    logic                  s1_last;
    logic                  adv;
    logic                  issue;
    logic                  last_issue;
    logic                  start_ok;
    logic                  last_acc;
    logic                  load_fire;

    if (!cfg_legal(BANKS, DEPTH, ADDR_WIDTH)) begin : g_bad_cfg
        $error("weight_buffer_stream: BANKS*DEPTH exceeds 2**ADDR_WIDTH");
    end

`ifdef WEIGHT_BUFFER_LOAD_EN
    assign load_ready = ~busy;
    assign load_fire  = load_valid & load_ready;
`else
    assign load_fire  = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        busy       = (state != IDLE);
        adv        = ~q_valid | q_ready;
        issue      = (state == RUN) & adv;
        last_issue = (left == ONE);
        last_acc   = q_valid & q_ready & q_last;
        // A same-cycle load takes priority; the controller retries the start.
        start_ok   = (state == IDLE) & rd_start
                   & (rd_count != '0) & ~load_fire;
        unique case (state)
            IDLE:    if (start_ok) state_nx = RUN;
            RUN:     if (issue && last_issue) state_nx = DRAIN;
            DRAIN:   if (last_acc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            idx      <= '0;
            left     <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            q_valid  <= 1'b0;
            q_last   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                idx  <= rd_base;
                left <= rd_count;
            end else if (issue) begin
                idx  <= ADDR_WIDTH'(wrap_inc(32'(idx), DEPTH));
                left <= left - ONE;
            end
            if (adv) begin
                s1_valid <= issue;
                s1_last  <= issue & last_issue;
                q_valid  <= s1_valid;
                q_last   <= s1_last;
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [ADDR_WIDTH-1:0] addr_q;
        logic [ADDR_WIDTH-1:0] ram_addr;
        logic                  ram_we;
        logic [RW-1:0]         ram_wdata;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                addr_q <= '0;
            end else if (issue) begin
                addr_q <= idx + ADDR_WIDTH'(b * DEPTH);
            end
        end

`ifdef WEIGHT_BUFFER_LOAD_EN
        assign ram_we    = load_fire & (load_bank == ($clog2(BANKS))'(b));
        assign ram_wdata = load_data;
        assign ram_addr  = ram_we ? load_addr + ADDR_WIDTH'(b * DEPTH)
                                  : addr_q;
`else
        assign ram_we    = 1'b0;
        assign ram_wdata = '0;
        assign ram_addr  = addr_q;
`endif

        weight_bank_ram #(
            .WIDTH (RW),
            .WORDS (DEPTH),
            .AW    (ADDR_WIDTH),
            .BASE  (b * DEPTH)
        ) u_ram (
            .clk    (clk),
            .resetn (resetn),
            .ce     (adv & ~ram_we),
            .we     (ram_we),
            .addr   (ram_addr),
            .wdata  (ram_wdata),
            .dout   (q_data[b*RW +: RW])
        );
    end

    a_rd_base: assert property (@(posedge clk) disable iff (!resetn)
        start_ok |-> in_range(32'(rd_base), DEPTH));

`ifdef WEIGHT_BUFFER_LOAD_EN
    a_load_addr: assert property (@(posedge clk) disable iff (!resetn)
        load_fire |-> in_range(32'(load_addr), DEPTH));
`endif

endmodule

// File: tb/tb_weight_buffer_stream.sv
// Directed bench for weight_buffer_stream: run table plus stall/reset/load cases.
// Covers the WEIGHT_BUFFER_LOAD_EN load port when that macro is defined.
module tb_weight_buffer_stream;

    localparam int BWD = 18;
    localparam int LN  = 9;
    localparam int NB  = 2;
    localparam int DP  = 42;
    localparam int AW  = 12;
    localparam int RW  = LN * BWD;
    localparam int DW  = NB * RW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rd_start = 1'b0;
    logic [AW-1:0] rd_base = '0;
    logic [AW-1:0] rd_count = '0;
    logic          busy;
    logic          q_valid;
    logic          q_ready = 1'b1;
    logic          q_last;
    logic [DW-1:0] q_data;
`ifdef WEIGHT_BUFFER_LOAD_EN
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [0:0]    load_bank = '0;
    logic [AW-1:0] load_addr = '0;
    logic [RW-1:0] load_data = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [RW-1:0] exp_mem [NB][DP];

    typedef struct {
        int base;
        int count;
        int beats;
        int total;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    weight_buffer_stream dut (
        .clk      (clk),
        .resetn   (resetn),
        .rd_start (rd_start),
        .rd_base  (rd_base),
        .rd_count (rd_count),
        .busy     (busy),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_last   (q_last),
        .q_data   (q_data)
`ifdef WEIGHT_BUFFER_LOAD_EN
        ,
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_bank  (load_bank),
        .load_addr  (load_addr),
        .load_data  (load_data)
`endif
    );

    function automatic logic [RW-1:0] row_val(input int b, input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int l = 0; l < LN; l++) begin
            v[l*BWD +: BWD] = BWD'((b << 12) | (r << 6) | l);
        end
        return v;
    endfunction

    task automatic chk_i(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // cyc counts rising edges since the accepting edge.
    task automatic run(input int base, input int count, input bit rnd,
                       input int poke_cyc, input int rst_beat,
                       output int nbeats, output int first_cyc,
                       output int total_cyc);
        logic [DW-1:0] held_d;
        logic          held_l;
        bit            hold;
        int            r;
        nbeats = 0;
        first_cyc = -1;
        total_cyc = -1;
        hold = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        @(negedge clk);
        rd_base = AW'(base);
        rd_count = AW'(count);
        rd_start = 1'b1;
        q_ready = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        for (int cyc = 0; cyc <= 300; cyc++) begin
            if (hold) begin
                chk_v("stall_data", q_data, held_d);
                chk_i("stall_last", int'(q_last), int'(held_l));
            end
`ifdef WEIGHT_BUFFER_LOAD_EN
            if (cyc == 1) chk_i("load_ready_busy", int'(load_ready), 0);
`endif
            if (!busy && !q_valid) begin
                total_cyc = cyc;
                break;
            end
            if (q_valid && first_cyc < 0) first_cyc = cyc;
            if (q_valid && rst_beat == nbeats) begin
                resetn = 1'b0;
                total_cyc = cyc;
                break;
            end
            rd_start = (cyc == poke_cyc);
            if (cyc == poke_cyc) begin
                rd_base = AW'(30);
                rd_count = AW'(5);
            end
            q_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (q_valid) begin
                if (q_ready) begin
                    r = (base + nbeats) % DP;
                    chk_v("beat_data", q_data, {exp_mem[1][r], exp_mem[0][r]});
                    chk_i("beat_last", int'(q_last), int'(nbeats == count - 1));
                    nbeats++;
                end
                hold = !q_ready;
                held_d = q_data;
                held_l = q_last;
            end else begin
                hold = 1'b0;
            end
            @(negedge clk);
        end
        if (total_cyc < 0) chk_i("run_timeout", 1, 0);
        q_ready = 1'b1;
        rd_start = 1'b0;
    endtask

    initial begin
        int nb, fc, tc, nv;

        tbl[0] = '{base: 0,  count: 42, beats: 42, total: 44};
        tbl[1] = '{base: 40, count: 4,  beats: 4,  total: 6};
        tbl[2] = '{base: 5,  count: 2,  beats: 2,  total: 4};
        tbl[3] = '{base: 41, count: 1,  beats: 1,  total: 3};
        tbl[4] = '{base: 10, count: 0,  beats: 0,  total: 0};

        for (int r = 0; r < DP; r++) begin
            exp_mem[0][r] = row_val(0, r);
            exp_mem[1][r] = row_val(1, r);
            dut.g_bank[0].u_ram.mem[r] = row_val(0, r);
            dut.g_bank[1].u_ram.mem[r] = row_val(1, r);
        end

        repeat (2) @(negedge clk);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_q_valid", int'(q_valid), 0);
        chk_i("rst_q_last", int'(q_last), 0);
        chk_v("rst_q_data", q_data, '0);
`ifdef WEIGHT_BUFFER_LOAD_EN
        chk_i("rst_load_ready", int'(load_ready), 1);
`endif
        resetn = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i].base, tbl[i].count, 1'b0, -1, -1, nb, fc, tc);
            chk_i("tbl_beats", nb, tbl[i].beats);
            chk_i("tbl_total", tc, tbl[i].total);
            if (tbl[i].count != 0) chk_i("tbl_first", fc, 2);
        end

        // Count 0 must leave the block idle with no beats.
        nv = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || q_valid) nv++;
        end
        chk_i("noop_idle", nv, 0);

        run(3, 10, 1'b1, -1, -1, nb, fc, tc);
        chk_i("rnd_beats", nb, 10);
        chk_i("rnd_first", fc, 2);

        run(0, 20, 1'b0, 5, -1, nb, fc, tc);
        chk_i("busy_start_beats", nb, 20);
        chk_i("busy_start_total", tc, 22);

        run(0, 20, 1'b0, -1, 3, nb, fc, tc);
        #1;
        chk_i("abort_beats", nb, 3);
        chk_i("abort_busy", int'(busy), 0);
        chk_i("abort_q_valid", int'(q_valid), 0);
        chk_i("abort_q_last", int'(q_last), 0);
        chk_v("abort_q_data", q_data, '0);
        @(negedge clk);
        resetn = 1'b1;
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || q_valid) nv++;
        end
        chk_i("abort_quiet", nv, 0);
        run(5, 2, 1'b0, -1, -1, nb, fc, tc);
        chk_i("after_rst_beats", nb, 2);
        chk_i("after_rst_total", tc, 4);

`ifdef WEIGHT_BUFFER_LOAD_EN
        @(negedge clk);
        load_valid = 1'b1;
        load_bank = 1'b1;
        load_addr = AW'(7);
        load_data = '1;
        rd_start = 1'b1;
        rd_base = AW'(0);
        rd_count = AW'(3);
        @(negedge clk);
        load_valid = 1'b0;
        rd_start = 1'b0;
        exp_mem[1][7] = '1;
        chk_i("load_wins_busy", int'(busy), 0);
        chk_i("load_ready_idle", int'(load_ready), 1);
        run(7, 1, 1'b0, -1, -1, nb, fc, tc);
        chk_i("load_beats", nb, 1);
        run(6, 3, 1'b0, -1, -1, nb, fc, tc);
        chk_i("load_span_beats", nb, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
